// File: rtl/mig_tt_sweeper_if.sv
// Control, program and truth-table stream signals of the MIG truth-table sweeper.
// The master side programs gates and consumes the stream; the slave side is the sweeper.
interface mig_tt_sweeper_if #(
    parameter int unsigned N_IN      = 7,
    parameter int unsigned MAX_GATES = 16
);
    localparam int unsigned SEL_W  = $clog2(1 + N_IN + MAX_GATES);
    localparam int unsigned PROG_W = 3 * (SEL_W + 1);
    localparam int unsigned ADDR_W = $clog2(MAX_GATES);
    localparam int unsigned NG_W   = $clog2(MAX_GATES + 1);

    logic              prog_we;
    logic [ADDR_W-1:0] prog_addr;
    logic [PROG_W-1:0] prog_data;
    logic [NG_W-1:0]   num_gates;
    logic [SEL_W-1:0]  out_sel;
    logic              out_inv;
    logic              start;
    logic              busy;
    logic              done;
    logic              tt_valid;
    logic              tt_ready;
    logic              tt_bit;
    logic [N_IN-1:0]   tt_index;

    modport master (
        output prog_we, prog_addr, prog_data, num_gates, out_sel, out_inv, start, tt_ready,
        input  busy, done, tt_valid, tt_bit, tt_index
    );

    modport slave (
        input  prog_we, prog_addr, prog_data, num_gates, out_sel, out_inv, start, tt_ready,
        output busy, done, tt_valid, tt_bit, tt_index
    );
endinterface

// File: rtl/mig_tt_sweeper.sv
// Programmable majority-inverter-graph evaluator. For every input pattern p the gate list is
// evaluated one gate per cycle, then the selected operand is streamed out as one truth-table bit.
module mig_tt_sweeper #(
    parameter int unsigned N_IN      = 7,
    parameter int unsigned MAX_GATES = 16
) (
    input logic             clk,
    input logic             rst,
    mig_tt_sweeper_if.slave sweep_io
);
    localparam int unsigned SEL_W  = $clog2(1 + N_IN + MAX_GATES);
    localparam int unsigned LIM_W  = SEL_W + 1;
    localparam int unsigned ENT_W  = SEL_W + 1;
    localparam int unsigned PROG_W = 3 * ENT_W;
    localparam int unsigned ADDR_W = $clog2(MAX_GATES);
    localparam int unsigned NG_W   = $clog2(MAX_GATES + 1);
    localparam int unsigned SPAN   = 2 ** SEL_W;

    typedef enum logic [1:0] {StIdle, StEval, StEmit, StFin} state_e;

    state_e              state_q, state_d;
    logic [PROG_W-1:0]   prog_q [MAX_GATES];
    logic [MAX_GATES-1:0] w_q;
    logic [N_IN-1:0]     p_q;
    logic [ADDR_W-1:0]   k_q;
    logic [NG_W-1:0]     ng_q;
    logic [SEL_W-1:0]    osel_q;
    logic                oinv_q;

    logic [SPAN-1:0]     src;
    logic [LIM_W-1:0]    lim;
    logic [NG_W-1:0]     ng_sat;
    logic [PROG_W-1:0]   entry;
    logic                op_a, op_b, op_c;
    logic                gate_val, emit_bit, last_gate, last_pat;

    // Selector decode: sel above N_IN+num_gates (or past the source vector) reads 0.
    function automatic logic operand(input logic [ENT_W-1:0] f, input logic [SPAN-1:0] s,
                                     input logic [LIM_W-1:0] l);
        logic [SEL_W-1:0] sel;
        logic             raw;
        sel = f[SEL_W-1:0];
        raw = (LIM_W'(sel) <= l) ? s[sel] : 1'b0;
        return raw ^ f[ENT_W-1];
    endfunction

    // Operand sources {gates, inputs, const 0} plus gate evaluation and output bit
    always_comb begin
        src                          = '0;
        src[N_IN:1]                  = p_q;
        src[N_IN+MAX_GATES:N_IN+1]   = w_q;
        lim       = LIM_W'(N_IN) + LIM_W'(ng_q);
        ng_sat    = (sweep_io.num_gates > NG_W'(MAX_GATES)) ? NG_W'(MAX_GATES)
                                                             : sweep_io.num_gates;
        entry     = prog_q[k_q];
        op_a      = operand(entry[3*ENT_W-1:2*ENT_W], src, lim);
        op_b      = operand(entry[2*ENT_W-1:ENT_W], src, lim);
        op_c      = operand(entry[ENT_W-1:0], src, lim);
        gate_val  = (op_a & op_b) | (op_a & op_c) | (op_b & op_c);
        emit_bit  = operand({oinv_q, osel_q}, src, lim);
        last_gate = (NG_W'(k_q) + NG_W'(1)) == ng_q;
        last_pat  = &p_q;
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state; zero-gate sweeps stay in EMIT so each pattern costs one cycle
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (sweep_io.start) begin
                    state_d = (ng_sat == '0) ? StEmit : StEval;
                end
            end
            StEval: begin
                if (last_gate) begin
                    state_d = StEmit;
                end
            end
            StEmit: begin
                if (sweep_io.tt_ready) begin
                    if (last_pat) begin
                        state_d = StFin;
                    end else begin
                        state_d = (ng_q == '0) ? StEmit : StEval;
                    end
                end
            end
            StFin: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs; stream fields are zero outside EMIT
    always_comb begin
        sweep_io.busy     = (state_q != StIdle);
        sweep_io.done     = (state_q == StFin);
        sweep_io.tt_valid = (state_q == StEmit);
        sweep_io.tt_bit   = (state_q == StEmit) & emit_bit;
        sweep_io.tt_index = (state_q == StEmit) ? p_q : '0;
    end

    // Program memory, sweep configuration, pattern/gate counters and gate value registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < MAX_GATES; i++) begin
                prog_q[i] <= '0;
            end
            w_q    <= '0;
            p_q    <= '0;
            k_q    <= '0;
            ng_q   <= '0;
            osel_q <= '0;
            oinv_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (sweep_io.prog_we) begin
                        prog_q[sweep_io.prog_addr] <= sweep_io.prog_data;
                    end
                    if (sweep_io.start) begin
                        ng_q   <= ng_sat;
                        osel_q <= sweep_io.out_sel;
                        oinv_q <= sweep_io.out_inv;
                        p_q    <= '0;
                        k_q    <= '0;
                        w_q    <= '0;
                    end
                end
                StEval: begin
                    w_q[k_q] <= gate_val;
                    k_q      <= k_q + ADDR_W'(1);
                end
                StEmit: begin
                    // Clearing w per pattern makes forward/self references read 0
                    if (sweep_io.tt_ready && !last_pat) begin
                        p_q <= p_q + N_IN'(1);
                        k_q <= '0;
                        w_q <= '0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mig_tt_sweeper.sv
// Table-driven bench for mig_tt_sweeper (N_IN=3): each vector programs gates, sweeps, and
// checks the streamed bits against a queue of expected {index, bit} records.
module tb_mig_tt_sweeper;
    localparam int unsigned N_IN      = 3;
    localparam int unsigned MAX_GATES = 16;

    typedef struct packed {
        logic        prog;
        logic [17:0] g0;
        logic [17:0] g1;
        logic [4:0]  ng;
        logic [4:0]  osel;
        logic        oinv;
        logic [7:0]  tt;
        logic [15:0] cycles;
    } vec_t;

    typedef struct packed {
        logic [2:0] idx;
        logic       b;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];
    vec_t vecs[9];

    always #5 clk = ~clk;

    mig_tt_sweeper_if #(.N_IN(N_IN), .MAX_GATES(MAX_GATES)) bus ();

    mig_tt_sweeper #(.N_IN(N_IN), .MAX_GATES(MAX_GATES)) dut (
        .clk      (clk),
        .rst      (rst),
        .sweep_io (bus)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [17:0] gate(input bit ia, input int sa, input bit ib, input int sb_,
                                         input bit ic, input int sc);
        return {ia, 5'(sa), ib, 5'(sb_), ic, 5'(sc)};
    endfunction

    function automatic vec_t mk(input bit prog, input logic [17:0] g0, input logic [17:0] g1,
                                input int ng, input int osel, input bit inv,
                                input logic [7:0] tt, input int cyc);
        vec_t v;
        v.prog = prog; v.g0 = g0; v.g1 = g1; v.ng = 5'(ng); v.osel = 5'(osel);
        v.oinv = inv; v.tt = tt; v.cycles = 16'(cyc);
        return v;
    endfunction

    // Program (g1, then g0 together with start), sweep, score every handshake.
    task automatic run_sweep(input string tag, input vec_t v, input int stall_idx,
                             input int stall_len, input bit poke);
        int   cyc, last_hs, stalls;
        bit   done_seen, stall_on, stall_done;
        exp_t e;
        sb.delete();
        for (int p = 0; p < 8; p++) begin
            e.idx = 3'(p);
            e.b   = v.tt[p];
            sb.push_back(e);
        end
        if (v.prog) begin
            bus.prog_we = 1'b1; bus.prog_addr = 4'd1; bus.prog_data = v.g1;
            @(negedge clk);
            bus.prog_addr = 4'd0; bus.prog_data = v.g0;
        end
        bus.num_gates = v.ng; bus.out_sel = v.osel; bus.out_inv = v.oinv;
        bus.start = 1'b1; bus.tt_ready = 1'b1;
        @(negedge clk);
        bus.start = 1'b0; bus.prog_we = 1'b0;
        cyc = 1; last_hs = -1; stalls = 0;
        done_seen = 0; stall_on = 0; stall_done = 0;
        check({tag, " busy after start"}, int'(bus.busy), 1);
        while (cyc < 400 && !done_seen) begin
            bus.prog_we = 1'b0;
            bus.start   = 1'b0;
            if (poke && cyc == 2) begin
                // Attempted reprogram + restart while busy
                bus.prog_we = 1'b1; bus.prog_addr = 4'd0; bus.prog_data = gate(1, 0, 1, 0, 1, 0);
                bus.start = 1'b1; bus.num_gates = 5'd0; bus.out_sel = 5'd0; bus.out_inv = 1'b1;
            end
            if (bus.done) begin
                done_seen = 1;
                check({tag, " done cycle"}, cyc, last_hs + 1);
                check({tag, " queue drained"}, sb.size(), 0);
            end else if (stall_on) begin
                bus.tt_ready = 1'b0;
                e = sb[0];
                check({tag, " stall valid"}, int'(bus.tt_valid), 1);
                check({tag, " stall index"}, int'(bus.tt_index), int'(e.idx));
                check({tag, " stall bit"}, int'(bus.tt_bit), int'(e.b));
                stalls++;
                if (stalls >= stall_len) stall_on = 0;
            end else begin
                bus.tt_ready = 1'b1;
                if (bus.tt_valid) begin
                    if (sb.size() == 0) begin
                        errors++; checks++;
                        $display("FAIL %s extra bit: got index %0d, expected none", tag,
                                 bus.tt_index);
                    end else if (!stall_done && stall_idx >= 0 &&
                                 int'(bus.tt_index) == stall_idx) begin
                        bus.tt_ready = 1'b0;
                        stall_done = 1;
                        stalls = 1;
                        stall_on = (stall_len > 1);
                    end else begin
                        e = sb.pop_front();
                        check($sformatf("%s p%0d index", tag, e.idx), int'(bus.tt_index),
                              int'(e.idx));
                        check($sformatf("%s p%0d bit", tag, e.idx), int'(bus.tt_bit), int'(e.b));
                        last_hs = cyc;
                    end
                end
            end
            @(negedge clk);
            cyc++;
        end
        bus.tt_ready = 1'b1;
        if (!done_seen) begin
            errors++; checks++;
            $display("FAIL %s timeout: got no done, expected done within 400 cycles", tag);
        end else begin
            check({tag, " last handshake cycle"}, last_hs,
                  int'(v.cycles) + ((stall_idx >= 0) ? stall_len : 0));
            check({tag, " busy after done"}, int'(bus.busy), 0);
            check({tag, " done is a pulse"}, int'(bus.done), 0);
        end
    endtask

    initial begin
        bus.prog_we = 1'b0; bus.prog_addr = '0; bus.prog_data = '0; bus.num_gates = '0;
        bus.out_sel = '0; bus.out_inv = 1'b0; bus.start = 1'b0; bus.tt_ready = 1'b1;

        vecs[0] = mk(1, gate(0, 1, 0, 2, 0, 3), 18'd0, 1, 4, 0, 8'hE8, 16);
        vecs[1] = mk(1, gate(0, 1, 0, 2, 0, 3), 18'd0, 1, 4, 1, 8'h17, 16);
        vecs[2] = mk(0, 18'd0, 18'd0, 0, 1, 0, 8'hAA, 8);
        vecs[3] = mk(0, 18'd0, 18'd0, 0, 0, 1, 8'hFF, 8);
        vecs[4] = mk(0, 18'd0, 18'd0, 0, 3, 1, 8'h0F, 8);
        vecs[5] = mk(1, gate(0, 1, 0, 2, 0, 0), gate(0, 4, 0, 3, 1, 0), 2, 5, 0, 8'hF8, 24);
        vecs[6] = mk(1, gate(0, 5, 0, 1, 1, 0), gate(0, 4, 0, 3, 1, 0), 2, 4, 0, 8'hAA, 24);
        // num_gates=31 saturates to 16; unwritten gates are MAJ(0,0,0)
        vecs[7] = mk(0, 18'd0, 18'd0, 31, 4, 0, 8'hAA, 136);
        vecs[8] = mk(0, 18'd0, 18'd0, 0, 31, 1, 8'hFF, 8);

        @(negedge clk);
        @(negedge clk);
        check("reset busy", int'(bus.busy), 0);
        check("reset done", int'(bus.done), 0);
        check("reset tt_valid", int'(bus.tt_valid), 0);
        check("reset tt_bit", int'(bus.tt_bit), 0);
        check("reset tt_index", int'(bus.tt_index), 0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 9; i++) begin
            run_sweep($sformatf("vec%0d", i), vecs[i], -1, 0, 0);
            @(negedge clk);
        end

        // Backpressure at p=3 for 5 cycles, with a reprogram/restart attempt while busy
        run_sweep("stall", vecs[0], 3, 5, 1);
        @(negedge clk);
        run_sweep("after poke", mk(0, 18'd0, 18'd0, 1, 4, 0, 8'hE8, 16), -1, 0, 0);
        @(negedge clk);

        // Reset mid-sweep
        bus.num_gates = 5'd1; bus.out_sel = 5'd4; bus.out_inv = 1'b0;
        bus.start = 1'b1; bus.tt_ready = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (6) @(negedge clk);
        check("mid-sweep busy before reset", int'(bus.busy), 1);
        rst = 1'b1;
        #1;
        check("mid reset busy", int'(bus.busy), 0);
        check("mid reset tt_valid", int'(bus.tt_valid), 0);
        check("mid reset tt_bit", int'(bus.tt_bit), 0);
        check("mid reset tt_index", int'(bus.tt_index), 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("mid reset no done c%0d", i), int'(bus.done), 0);
        end
        rst = 1'b0;
        @(negedge clk);
        check("after reset idle", int'(bus.busy), 0);
        // Program memory was cleared, so gate 0 is MAJ(0,0,0)
        run_sweep("post reset", mk(0, 18'd0, 18'd0, 1, 4, 0, 8'h00, 16), -1, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
